data_mem_stack_unit: RTL and testbench

//  Parametrised data memory with an integrated hardware stack. Successor to the fixed 1 KiB data/stack memory.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/data_mem_stack_unit_if.sv | 32 +++
 rtl/byte_mem_array.sv | 34 +++
 rtl/data_mem_stack_unit.sv | 165 ++++++++++++++++
 tb/tb_data_mem_stack_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared opcodes, error codes and sizing constants for the data memory / stack unit.
package dm_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [1:0] err_code_t;

    localparam opcode_t OP_LW     = 6'b000101;
    localparam opcode_t OP_LW_POI = 6'b000110;
    localparam opcode_t OP_SW     = 6'b000111;
    localparam opcode_t OP_CALL   = 6'b001101;
    localparam opcode_t OP_RET    = 6'b001110;
    localparam opcode_t OP_PUSH   = 6'b001111;
    localparam opcode_t OP_POP    = 6'b010000;

    localparam err_code_t ERR_OVERFLOW  = 2'd0;
    localparam err_code_t ERR_UNDERFLOW = 2'd1;
    localparam err_code_t ERR_ADDR      = 2'd2;
    localparam err_code_t ERR_ILLEGAL   = 2'd3;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/data_mem_stack_unit_if.sv
// Execute-stage request/response bundle for the data memory / stack unit.
interface data_mem_stack_unit_if #(
    parameter int ADDR_W = 10
);
    logic              op_valid;
    logic [5:0]        opcode;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       address;
    logic [31:0]       data;
    logic [31:0]       pc;
    logic [31:0]       rs1;
    logic [31:0]       data_out;
    logic              rd_valid;
    logic [31:0]       stack_out;
    logic              ret_valid;
    logic [31:0]       rs1_inc;
    logic [ADDR_W:0]   sp;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output op_valid, opcode, mem_read, mem_write, address, data, pc, rs1,
        input  data_out, rd_valid, stack_out, ret_valid, rs1_inc, sp, err, err_code
    );

    modport slave (
        input  op_valid, opcode, mem_read, mem_write, address, data, pc, rs1,
        output data_out, rd_valid, stack_out, ret_valid, rs1_inc, sp, err, err_code
    );

endinterface

// File: rtl/byte_mem_array.sv
// Byte-addressable storage: one little-endian word written per cycle with per-lane
// enables, and an asynchronous 4-byte read at a base address.
module byte_mem_array
    import dm_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [31:0]           rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we[i]) begin
                mem[waddr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/data_mem_stack_unit.sv
// Data memory with an integrated downward-growing word stack sharing one byte array.
// Decodes execute-stage requests, checks them, and registers results with valid pulses.
module data_mem_stack_unit
    import dm_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int STACK_LIMIT = 768
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_stack_unit_if.slave bus
);

    localparam logic [ADDR_W:0] SP_EMPTY = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] SP_FLOOR = (ADDR_W+1)'(STACK_LIMIT + WORD_BYTES);
    localparam logic [ADDR_W:0] SP_STEP  = (ADDR_W+1)'(WORD_BYTES);

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:ADDR_W] == '0);
    endfunction

    logic [ADDR_W:0]       sp_p1;
    logic [ADDR_W:0]       sp_nxt_p0;
    logic [WORD_BYTES-1:0] we_p0;
    logic [WORD_BYTES-1:0] mem_we;
    logic [ADDR_W-1:0]     waddr_p0;
    logic [ADDR_W-1:0]     raddr_p0;
    logic [31:0]           wdata_p0;
    logic [31:0]           rdata_p0;
    logic                  rd_p0;
    logic                  ret_p0;
    logic                  poi_p0;
    logic                  err_p0;
    err_code_t             code_p0;

    logic [31:0]           data_out_p1;
    logic [31:0]           stack_out_p1;
    logic [31:0]           rs1_inc_p1;
    logic                  vld_rd_p1;
    logic                  vld_ret_p1;
    logic                  err_p1;
    err_code_t             err_code_p1;

    // Stage p0: decode, legality checks, write strobes and next stack pointer
    always_comb begin
        sp_nxt_p0 = sp_p1;
        we_p0     = '0;
        waddr_p0  = bus.address[ADDR_W-1:0];
        raddr_p0  = bus.address[ADDR_W-1:0];
        wdata_p0  = bus.data;
        rd_p0     = 1'b0;
        ret_p0    = 1'b0;
        poi_p0    = 1'b0;
        err_p0    = 1'b0;
        code_p0   = ERR_OVERFLOW;
        if (bus.op_valid) begin
            case (bus.opcode)
                OP_LW, OP_LW_POI: begin
                    if (bus.mem_read) begin
                        if (!addr_ok(bus.address)) begin
                            err_p0  = 1'b1;
                            code_p0 = ERR_ADDR;
                        end else begin
                            rd_p0  = 1'b1;
                            poi_p0 = (bus.opcode == OP_LW_POI);
                        end
                    end
                end
                OP_SW: begin
                    if (bus.mem_write) begin
                        if (!addr_ok(bus.address)) begin
                            err_p0  = 1'b1;
                            code_p0 = ERR_ADDR;
                        end else begin
                            we_p0 = '1;
                        end
                    end
                end
                OP_PUSH, OP_CALL: begin
                    if (sp_p1 < SP_FLOOR) begin
                        err_p0  = 1'b1;
                        code_p0 = ERR_OVERFLOW;
                    end else begin
                        sp_nxt_p0 = sp_p1 - SP_STEP;
                        we_p0     = '1;
                        waddr_p0  = sp_nxt_p0[ADDR_W-1:0];
                        wdata_p0  = (bus.opcode == OP_CALL) ? bus.pc + 32'd1 : bus.data;
                    end
                end
                OP_POP, OP_RET: begin
                    if (sp_p1 == SP_EMPTY) begin
                        err_p0  = 1'b1;
                        code_p0 = ERR_UNDERFLOW;
                    end else begin
                        raddr_p0  = sp_p1[ADDR_W-1:0];
                        sp_nxt_p0 = sp_p1 + SP_STEP;
                        rd_p0     = (bus.opcode == OP_POP);
                        ret_p0    = (bus.opcode == OP_RET);
                    end
                end
                default: begin
                    err_p0  = 1'b1;
                    code_p0 = ERR_ILLEGAL;
                end
            endcase
        end
    end

    // Reset suppresses any write requested in the same cycle.
    assign mem_we = we_p0 & {WORD_BYTES{~rst}};

    byte_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr_p0),
        .wdata (wdata_p0),
        .raddr (raddr_p0),
        .rdata (rdata_p0)
    );

    // Stage p1: registered results, pulses and stack pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_p1        <= SP_EMPTY;
            data_out_p1  <= '0;
            stack_out_p1 <= '0;
            rs1_inc_p1   <= '0;
            vld_rd_p1    <= 1'b0;
            vld_ret_p1   <= 1'b0;
            err_p1       <= 1'b0;
            err_code_p1  <= ERR_OVERFLOW;
        end else begin
            sp_p1      <= sp_nxt_p0;
            vld_rd_p1  <= rd_p0;
            vld_ret_p1 <= ret_p0;
            err_p1     <= err_p0;
            if (err_p0) begin
                err_code_p1 <= code_p0;
            end
            if (rd_p0) begin
                data_out_p1 <= rdata_p0;
            end
            if (ret_p0) begin
                stack_out_p1 <= rdata_p0;
            end
            if (poi_p0) begin
                rs1_inc_p1 <= bus.rs1 + 32'd1;
            end
        end
    end

    assign bus.sp        = sp_p1;
    assign bus.data_out  = data_out_p1;
    assign bus.stack_out = stack_out_p1;
    assign bus.rs1_inc   = rs1_inc_p1;
    assign bus.rd_valid  = vld_rd_p1;
    assign bus.ret_valid = vld_ret_p1;
    assign bus.err       = err_p1;
    assign bus.err_code  = err_code_p1;

endmodule

// File: tb/tb_data_mem_stack_unit.sv
// Bench for data_mem_stack_unit: directed vector table, stack corner sequences,
// then random traffic compared against a byte-array / integer stack-pointer model.
module tb_data_mem_stack_unit;

    localparam logic [5:0] C_LW    = 6'b000101;
    localparam logic [5:0] C_LWPOI = 6'b000110;
    localparam logic [5:0] C_SW    = 6'b000111;
    localparam logic [5:0] C_CALL  = 6'b001101;
    localparam logic [5:0] C_RET   = 6'b001110;
    localparam logic [5:0] C_PUSH  = 6'b001111;
    localparam logic [5:0] C_POP   = 6'b010000;
    localparam logic [5:0] C_BAD   = 6'b111111;
    localparam int MEM_BYTES = 1024;
    localparam int LIMIT     = 768;

    logic clk;
    logic rst;

    data_mem_stack_unit_if #(.ADDR_W(10)) bus ();

    data_mem_stack_unit #(
        .DEPTH       (1024),
        .ADDR_W      (10),
        .STACK_LIMIT (768)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [7:0]  m_mem [MEM_BYTES];
    int          m_sp;
    logic [31:0] m_dout, m_stk, m_inc;
    logic        m_rdv, m_retv, m_err;
    logic [1:0]  m_code;

    typedef struct {
        logic        ov;
        logic [5:0]  opc;
        logic        mr;
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] s;
        logic        erd;
        logic        eret;
        logic        eerr;
        logic [1:0]  ecode;
        logic [31:0] edout;
        logic [31:0] estk;
        logic [31:0] einc;
        int          esp;
    } vec_t;

    function automatic vec_t mk(input logic ov, input logic [5:0] opc, input logic mr,
                                input logic mw, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] p, input logic [31:0] s, input logic erd,
                                input logic eret, input logic eerr, input logic [1:0] ecode,
                                input logic [31:0] edout, input logic [31:0] estk,
                                input logic [31:0] einc, input int esp);
        vec_t v;
        v.ov = ov; v.opc = opc; v.mr = mr; v.mw = mw; v.a = a; v.d = d; v.p = p; v.s = s;
        v.erd = erd; v.eret = eret; v.eerr = eerr; v.ecode = ecode;
        v.edout = edout; v.estk = estk; v.einc = einc; v.esp = esp;
        return v;
    endfunction

    function automatic logic [31:0] rdw(input int a);
        return {m_mem[(a+3) % MEM_BYTES], m_mem[(a+2) % MEM_BYTES],
                m_mem[(a+1) % MEM_BYTES], m_mem[a % MEM_BYTES]};
    endfunction

    function automatic void wrw(input int a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) m_mem[(a+i) % MEM_BYTES] = v[8*i +: 8];
    endfunction

    function automatic void raise(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
    endfunction

    function automatic void model_step(input logic r, input logic ov, input logic [5:0] opc,
                                       input logic mr, input logic mw, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] p,
                                       input logic [31:0] s);
        logic bad_addr;
        bad_addr = (a[1:0] != 2'b00) || (a >= 32'(MEM_BYTES));
        if (r) begin
            m_sp = MEM_BYTES; m_dout = 0; m_stk = 0; m_inc = 0;
            m_rdv = 0; m_retv = 0; m_err = 0; m_code = 0;
            return;
        end
        m_rdv = 0; m_retv = 0; m_err = 0;
        if (!ov) return;
        case (opc)
            C_LW, C_LWPOI: if (mr) begin
                if (bad_addr) raise(2);
                else begin
                    m_rdv  = 1;
                    m_dout = rdw(int'(a));
                    if (opc == C_LWPOI) m_inc = s + 32'd1;
                end
            end
            C_SW: if (mw) begin
                if (bad_addr) raise(2);
                else wrw(int'(a), d);
            end
            C_PUSH, C_CALL: begin
                if (m_sp - 4 < LIMIT) raise(0);
                else begin
                    m_sp = m_sp - 4;
                    wrw(m_sp, (opc == C_CALL) ? p + 32'd1 : d);
                end
            end
            C_POP, C_RET: begin
                if (m_sp == MEM_BYTES) raise(1);
                else begin
                    if (opc == C_POP) begin m_rdv = 1; m_dout = rdw(m_sp); end
                    else begin m_retv = 1; m_stk = rdw(m_sp); end
                    m_sp = m_sp + 4;
                end
            end
            default: raise(3);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic ov, input logic [5:0] opc, input logic mr,
                         input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] s);
        @(negedge clk);
        rst = r;
        bus.op_valid = ov; bus.opcode = opc; bus.mem_read = mr; bus.mem_write = mw;
        bus.address = a; bus.data = d; bus.pc = p; bus.rs1 = s;
        @(posedge clk);
        model_step(r, ov, opc, mr, mw, a, d, p, s);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rd_valid"},  32'(bus.rd_valid),  32'(m_rdv));
        check({tag, " ret_valid"}, 32'(bus.ret_valid), 32'(m_retv));
        check({tag, " err"},       32'(bus.err),       32'(m_err));
        check({tag, " err_code"},  32'(bus.err_code),  32'(m_code));
        check({tag, " data_out"},  bus.data_out,       m_dout);
        check({tag, " stack_out"}, bus.stack_out,      m_stk);
        check({tag, " rs1_inc"},   bus.rs1_inc,        m_inc);
        check({tag, " sp"},        32'(bus.sp),        32'(m_sp));
    endtask

    vec_t tbl [22];

    initial begin
        logic [5:0] legal [7];
        legal = '{C_LW, C_LWPOI, C_SW, C_CALL, C_RET, C_PUSH, C_POP};

        rst = 1'b1;
        bus.op_valid = 0; bus.opcode = 0; bus.mem_read = 0; bus.mem_write = 0;
        bus.address = 0; bus.data = 0; bus.pc = 0; bus.rs1 = 0;
        for (int i = 0; i < MEM_BYTES; i++) m_mem[i] = 8'h00;

        repeat (3) apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset sp",        32'(bus.sp),        32'd1024);
        check("reset data_out",  bus.data_out,       32'd0);
        check("reset stack_out", bus.stack_out,      32'd0);
        check("reset rs1_inc",   bus.rs1_inc,        32'd0);
        check("reset rd_valid",  32'(bus.rd_valid),  32'd0);
        check("reset ret_valid", 32'(bus.ret_valid), 32'd0);
        check("reset err",       32'(bus.err),       32'd0);
        check("reset err_code",  32'(bus.err_code),  32'd0);

        // Known contents everywhere so every later read is predictable.
        for (int i = 0; i < MEM_BYTES / 4; i++)
            apply(0, 1, C_SW, 0, 1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 0, 0);

        tbl[0]  = mk(1, C_SW,    0, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1024);
        tbl[1]  = mk(1, C_LW,    1, 0, 32'h10,  0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 1024);
        tbl[2]  = mk(1, C_PUSH,  0, 0, 0, 32'h11, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 1020);
        tbl[3]  = mk(1, C_PUSH,  0, 0, 0, 32'h22, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 1016);
        tbl[4]  = mk(1, C_POP,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h22, 32'h0, 0, 1020);
        tbl[5]  = mk(1, C_POP,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h11, 32'h0, 0, 1024);
        tbl[6]  = mk(1, C_CALL,  0, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0, 32'h11, 32'h0, 0, 1020);
        tbl[7]  = mk(1, C_RET,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h11, 32'h41, 0, 1024);
        tbl[8]  = mk(1, C_POP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11, 32'h41, 0, 1024);
        tbl[9]  = mk(1, C_SW,    0, 1, 32'h13, 32'h12345678, 0, 0, 0, 0, 1, 2, 32'h11, 32'h41, 0, 1024);
        tbl[10] = mk(1, C_LW,    1, 0, 32'h14, 0, 0, 0, 1, 0, 0, 2, 32'hC0DE0005, 32'h41, 0, 1024);
        tbl[11] = mk(1, C_LWPOI, 1, 0, 32'h20, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 2, 32'hC0DE0008, 32'h41, 0, 1024);
        tbl[12] = mk(1, C_BAD,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hC0DE0008, 32'h41, 0, 1024);
        tbl[13] = mk(1, C_LW,    0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 3, 32'hC0DE0008, 32'h41, 0, 1024);
        tbl[14] = mk(1, C_SW,    0, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 3, 32'hC0DE0008, 32'h41, 0, 1024);
        tbl[15] = mk(1, C_LW,    1, 0, 32'h10, 0, 0, 0, 1, 0, 0, 3, 32'hDEADBEEF, 32'h41, 0, 1024);
        tbl[16] = mk(0, C_BAD,   0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 32'h41, 0, 1024);
        tbl[17] = mk(1, C_LW,    1, 0, 32'h400, 0, 0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 32'h41, 0, 1024);
        tbl[18] = mk(1, C_LWPOI, 1, 0, 32'h22, 0, 0, 32'h5, 0, 0, 1, 2, 32'hDEADBEEF, 32'h41, 0, 1024);
        tbl[19] = mk(1, C_SW,    0, 1, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2, 32'hDEADBEEF, 32'h41, 0, 1024);
        tbl[20] = mk(1, C_LW,    1, 0, 32'h300, 0, 0, 0, 1, 0, 0, 2, 32'hCAFEF00D, 32'h41, 0, 1024);
        tbl[21] = mk(1, C_LWPOI, 1, 0, 32'h24, 0, 0, 32'h7, 1, 0, 0, 2, 32'hC0DE0009, 32'h41, 32'h8, 1024);

        for (int i = 0; i < 22; i++) begin
            apply(0, tbl[i].ov, tbl[i].opc, tbl[i].mr, tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].p, tbl[i].s);
            check($sformatf("row%0d rd_valid", i),  32'(bus.rd_valid),  32'(tbl[i].erd));
            check($sformatf("row%0d ret_valid", i), 32'(bus.ret_valid), 32'(tbl[i].eret));
            check($sformatf("row%0d err", i),       32'(bus.err),       32'(tbl[i].eerr));
            check($sformatf("row%0d err_code", i),  32'(bus.err_code),  32'(tbl[i].ecode));
            check($sformatf("row%0d data_out", i),  bus.data_out,       tbl[i].edout);
            check($sformatf("row%0d stack_out", i), bus.stack_out,      tbl[i].estk);
            check($sformatf("row%0d rs1_inc", i),   bus.rs1_inc,        tbl[i].einc);
            check($sformatf("row%0d sp", i),        32'(bus.sp),        32'(tbl[i].esp));
        end
        check("byte 0x10 little-endian", 32'(dut.u_mem.mem[16]), 32'hEF);

        // Fill the stack to its limit, then overflow once.
        for (int i = 0; i < 64; i++) begin
            apply(0, 1, C_PUSH, 0, 0, 0, 32'hB0000000 + 32'(i), 0, 0);
            check($sformatf("fill push%0d sp", i), 32'(bus.sp), 32'(1020 - 4 * i));
        end
        apply(0, 1, C_PUSH, 0, 0, 0, 32'hFFFFFFFF, 0, 0);
        check("overflow err",      32'(bus.err),      32'd1);
        check("overflow err_code", 32'(bus.err_code), 32'd0);
        check("overflow sp",       32'(bus.sp),       32'd768);
        apply(0, 1, C_LW, 1, 0, 32'h2FC, 0, 0, 0);
        check("below limit untouched", bus.data_out, 32'hC0DE00BF);
        for (int i = 0; i < 64; i++) begin
            apply(0, 1, C_POP, 0, 0, 0, 0, 0, 0);
            check($sformatf("drain pop%0d data", i), bus.data_out, 32'hB0000000 + 32'(63 - i));
            check($sformatf("drain pop%0d sp", i),   32'(bus.sp),  32'(772 + 4 * i));
        end

        // Reset colliding with a PUSH at sp=1000.
        for (int i = 0; i < 6; i++) apply(0, 1, C_PUSH, 0, 0, 0, 32'h60 + 32'(i), 0, 0);
        check("pre-reset sp", 32'(bus.sp), 32'd1000);
        apply(0, 1, C_POP, 0, 0, 0, 0, 0, 0);
        apply(0, 1, C_PUSH, 0, 0, 0, 32'h65, 0, 0);
        apply(1, 1, C_PUSH, 0, 0, 0, 32'h77, 0, 0);
        check("rst+push sp",        32'(bus.sp),        32'd1024);
        check("rst+push rd_valid",  32'(bus.rd_valid),  32'd0);
        check("rst+push ret_valid", 32'(bus.ret_valid), 32'd0);
        check("rst+push err",       32'(bus.err),       32'd0);
        check("rst+push data_out",  bus.data_out,       32'd0);
        apply(0, 1, C_LW, 1, 0, 32'h3E4, 0, 0, 0);
        check("rst+push no write", bus.data_out, 32'hB0000006);

        for (int n = 0; n < 3000; n++) begin
            int          k;
            logic [5:0]  opc;
            logic [31:0] a;
            logic        r;
            k   = $urandom_range(0, 9);
            opc = (k < 7) ? legal[k] : 6'($urandom_range(0, 63));
            if (k >= 2 && k <= 5 && $urandom_range(0, 1) == 1) opc = (k == 5) ? C_CALL : C_PUSH;
            a   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            r   = ($urandom_range(0, 199) == 0);
            apply(r, (k != 9) || ($urandom_range(0, 1) == 1), opc,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                  a, 32'($urandom), 32'($urandom), 32'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
